// File: rtl/vfd_pkg.sv
// rtl/vfd_pkg.sv - Shared widths, FSM encoding and high-time helper for the VFD PWM generator
package vfd_pkg;

    localparam int PER_W  = 16;
    localparam int DUTY_W = 8;
    localparam int FREQ_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RUN  = 2'd2
    } vfd_state_t;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_RUN  = ST_RUN;

    // 24-bit product, upper 16 bits kept: high = period * duty / 256
    function automatic logic [PER_W-1:0] high_time(input logic [PER_W-1:0] per,
                                                   input logic [DUTY_W-1:0] d);
        return PER_W'((24'(per) * 24'(d)) >> DUTY_W);
    endfunction

endpackage

// File: rtl/vfd_pwm_gen_if.sv
// rtl/vfd_pwm_gen_if.sv - Control and status bundle between the HMI side and the PWM generator
interface vfd_pwm_gen_if;
    import vfd_pkg::*;

    logic              pluse_us;
    logic              en;
    logic [FREQ_W-1:0] freq;
    logic [DUTY_W-1:0] duty;
    logic              pwm;
    logic [DUTY_W-1:0] cur_duty;
    logic              busy;
    logic              range_err;

    modport master (
        output pluse_us, en, freq, duty,
        input  pwm, cur_duty, busy, range_err
    );

    modport slave (
        input  pluse_us, en, freq, duty,
        output pwm, cur_duty, busy, range_err
    );

endinterface

// File: rtl/div16x10.sv
// rtl/div16x10.sv - Sequential restoring divider, 16-bit dividend by 10-bit divisor, one bit per cycle
module div16x10 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] dividend,
    input  logic [9:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic [9:0]  rem;
    logic [9:0]  dvs;
    logic [15:0] quo;
    logic [3:0]  iter;
    logic [10:0] shifted;
    logic [9:0]  sub;
    logic        borrow;

    // Remainder stays below the divisor, so the low 10 bits of the difference are exact
    always_comb begin
        shifted = {rem, quo[15]};
        borrow  = shifted < {1'b0, dvs};
        sub     = shifted[9:0] - dvs;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= '0;
                dvs  <= divisor;
                quo  <= dividend;
                iter <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (borrow) begin
                    rem <= shifted[9:0];
                    quo <= {quo[14:0], 1'b0};
                end else begin
                    rem <= sub;
                    quo <= {quo[14:0], 1'b1};
                end
                iter <= iter + 4'd1;
                if (iter == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/vfd_pwm_gen.sv
// rtl/vfd_pwm_gen.sv - VFD boost PWM: freq-to-period divider, soft-start duty ramp, glitch-free reload
module vfd_pwm_gen
    import vfd_pkg::*;
#(
    parameter int CLK_KHZ  = 50000,
    parameter int MAX_FREQ = 500,
    parameter int RAMP_US  = 100
) (
    input  logic         clk_sys,
    input  logic         rst,
    vfd_pwm_gen_if.slave bus
);

    localparam logic [PER_W-1:0]  DIVIDEND = PER_W'(CLK_KHZ);
    localparam logic [FREQ_W:0]   MAX_F    = (FREQ_W + 1)'(MAX_FREQ);
    localparam logic [15:0]       RAMP_TOP = 16'(RAMP_US - 1);

    logic [1:0]        state;
    logic [FREQ_W-1:0] freq_lat;
    logic [PER_W-1:0]  period;
    logic [PER_W-1:0]  shadow;
    logic              shadow_pend;
    logic [PER_W-1:0]  cnt;
    logic [PER_W-1:0]  high;
    logic [DUTY_W-1:0] cur_duty;
    logic              pwm_q;
    logic [15:0]       ramp_cnt;

    logic              range_err;
    logic              halt;
    logic              freq_chg;
    logic              wrap;
    logic              ramp_tick;
    logic [PER_W-1:0]  next_per;

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [PER_W-1:0]  div_q;

    always_comb begin
        range_err = (bus.freq == '0) || ({1'b0, bus.freq} > MAX_F);
        halt      = !bus.en || range_err;
        freq_chg  = bus.freq != freq_lat;
        // IDLE always launches a division; elsewhere only a new freq value does
        div_start = !halt && ((state == S_IDLE) || freq_chg);
        wrap      = (state == S_RUN) && (({1'b0, cnt} + 17'd1) >= {1'b0, period});
        next_per  = shadow_pend ? shadow : period;
        ramp_tick = bus.pluse_us && (ramp_cnt == RAMP_TOP);
    end

    div16x10 u_div (
        .clk      (clk_sys),
        .rst      (rst),
        .start    (div_start),
        .abort    (halt),
        .dividend (DIVIDEND),
        .divisor  (bus.freq),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state       <= S_IDLE;
            freq_lat    <= '0;
            period      <= '0;
            shadow      <= '0;
            shadow_pend <= 1'b0;
            cnt         <= '0;
            high        <= '0;
            cur_duty    <= '0;
            pwm_q       <= 1'b0;
            ramp_cnt    <= '0;
        end else if (halt) begin
            state       <= S_IDLE;
            period      <= '0;
            shadow_pend <= 1'b0;
            cnt         <= '0;
            high        <= '0;
            cur_duty    <= '0;
            pwm_q       <= 1'b0;
            ramp_cnt    <= '0;
        end else begin
            if (div_start) begin
                freq_lat <= bus.freq;
            end
            case (state)
                S_IDLE: begin
                    pwm_q <= 1'b0;
                    state <= S_CALC;
                end
                S_CALC: begin
                    pwm_q <= 1'b0;
                    if (div_done && !div_start) begin
                        shadow <= div_q;
                        period <= div_q;
                        cnt    <= '0;
                        high   <= high_time(div_q, cur_duty);
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    pwm_q <= cnt < high;
                    // Period and high time only ever change on a wrap, so pulses are never cut
                    if (wrap) begin
                        cnt         <= '0;
                        period      <= next_per;
                        high        <= high_time(next_per, cur_duty);
                        shadow_pend <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (div_done && !div_start) begin
                        shadow      <= div_q;
                        shadow_pend <= 1'b1;
                    end
                    if (bus.pluse_us) begin
                        ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 16'd1;
                    end
                    if (cur_duty > bus.duty) begin
                        cur_duty <= bus.duty;
                    end else if (ramp_tick && (cur_duty < bus.duty)) begin
                        cur_duty <= cur_duty + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pwm       = pwm_q;
    assign bus.cur_duty  = cur_duty;
    assign bus.busy      = div_busy;
    assign bus.range_err = range_err;

endmodule

// File: tb/tb_vfd_pwm_gen.sv
// tb/tb_vfd_pwm_gen.sv - Directed vector bench for vfd_pwm_gen
module tb_vfd_pwm_gen;

    localparam int CLK_KHZ  = 50000;
    localparam int MAX_FREQ = 500;
    localparam int RAMP_US  = 3;
    localparam int US_CYC   = 5;
    localparam int NVEC     = 9;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    vfd_pwm_gen_if bus();

    vfd_pwm_gen #(
        .CLK_KHZ  (CLK_KHZ),
        .MAX_FREQ (MAX_FREQ),
        .RAMP_US  (RAMP_US)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [9:0] freq;
        logic [7:0] duty;
        bit         err;
        int         per;
        int         hi;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rise(input int limit, output bit ok);
        logic last;
        last = bus.pwm;
        ok   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (bus.pwm && !last) begin
                ok = 1'b1;
                break;
            end
            last = bus.pwm;
        end
    endtask

    task automatic measure(output int hi, output int per);
        bit   ok;
        logic last;
        hi  = 0;
        per = 0;
        wait_rise(3000, ok);
        if (ok) begin
            hi   = 1;
            per  = 1;
            last = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk_sys);
                if (bus.pwm && !last) break;
                per++;
                if (bus.pwm) hi++;
                last = bus.pwm;
            end
        end
    endtask

    task automatic settle(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk_sys);
            if (!bus.busy && bus.cur_duty == d) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bus.pluse_us = 1'b0;
        forever begin
            repeat (US_CYC - 1) @(negedge clk_sys);
            bus.pluse_us = 1'b1;
            @(negedge clk_sys);
            bus.pluse_us = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi, per, bcnt, k;
        bit   ok;

        vecs[0] = '{freq: 10'd100, duty: 8'd128, err: 1'b0, per: 500, hi: 250};
        vecs[1] = '{freq: 10'd200, duty: 8'd128, err: 1'b0, per: 250, hi: 125};
        vecs[2] = '{freq: 10'd250, duty: 8'd64,  err: 1'b0, per: 200, hi: 50};
        vecs[3] = '{freq: 10'd500, duty: 8'd255, err: 1'b0, per: 100, hi: 99};
        vecs[4] = '{freq: 10'd333, duty: 8'd100, err: 1'b0, per: 150, hi: 58};
        vecs[5] = '{freq: 10'd0,   duty: 8'd100, err: 1'b1, per: 0,   hi: 0};
        vecs[6] = '{freq: 10'd501, duty: 8'd100, err: 1'b1, per: 0,   hi: 0};
        vecs[7] = '{freq: 10'd250, duty: 8'd128, err: 1'b0, per: 200, hi: 100};
        vecs[8] = '{freq: 10'd499, duty: 8'd200, err: 1'b0, per: 100, hi: 78};

        bus.en   = 1'b0;
        bus.freq = 10'd100;
        bus.duty = 8'd128;

        repeat (3) @(negedge clk_sys);
        check("rst_pwm", int'(bus.pwm), 0);
        check("rst_cur_duty", int'(bus.cur_duty), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_range_err", int'(bus.range_err), 0);
        rst = 1'b0;
        @(negedge clk_sys);
        check("idle_busy", int'(bus.busy), 0);

        bus.en = 1'b1;
        @(negedge clk_sys);
        check("busy_latency", int'(bus.busy), 1);
        bcnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (!bus.busy) break;
            bcnt++;
        end
        check("busy_len", bcnt, 16);

        for (int v = 0; v < NVEC; v++) begin
            bus.freq = vecs[v].freq;
            bus.duty = vecs[v].duty;
            if (vecs[v].err) begin
                @(negedge clk_sys);
                check($sformatf("v%0d_range_err", v), int'(bus.range_err), 1);
                k = 0;
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk_sys);
                    if (bus.pwm) k++;
                end
                check($sformatf("v%0d_pwm_high_cycles", v), k, 0);
                check($sformatf("v%0d_cur_duty", v), int'(bus.cur_duty), 0);
                check($sformatf("v%0d_busy", v), int'(bus.busy), 0);
            end else begin
                settle(vecs[v].duty, ok);
                check($sformatf("v%0d_settle", v), int'(ok), 1);
                check($sformatf("v%0d_range_err", v), int'(bus.range_err), 0);
                wait_rise(3000, ok);
                wait_rise(3000, ok);
                measure(hi, per);
                check($sformatf("v%0d_period", v), per, vecs[v].per);
                check($sformatf("v%0d_high", v), hi, vecs[v].hi);
            end
        end

        // Frequency change mid-period: the running 500-cycle period must finish intact
        bus.freq = 10'd100;
        bus.duty = 8'd128;
        settle(8'd128, ok);
        wait_rise(3000, ok);
        wait_rise(3000, ok);
        wait_rise(3000, ok);
        check("chg_rise", int'(ok), 1);
        hi = 1; per = 1; bcnt = 0;
        begin
            logic last;
            last = 1'b1;
            for (int i = 0; i < 2000; i++) begin
                if (i == 100) bus.freq = 10'd200;
                @(negedge clk_sys);
                if (bus.busy) bcnt++;
                if (bus.pwm && !last) break;
                per++;
                if (bus.pwm) hi++;
                last = bus.pwm;
            end
        end
        check("chg_old_period", per, 500);
        check("chg_old_high", hi, 250);
        check("chg_busy_len", bcnt, 16);
        for (int p = 0; p < 2; p++) begin
            measure(hi, per);
            check($sformatf("chg_new_period%0d", p), per, 250);
            check($sformatf("chg_new_high%0d", p), hi, 125);
        end

        // Two changes inside one division: only the last value is applied
        bus.freq = 10'd100;
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) bus.freq = 10'd250;
            @(negedge clk_sys);
            if (bus.busy) bcnt++;
        end
        check("dbl_busy_len", bcnt, 21);
        wait_rise(3000, ok);
        for (int p = 0; p < 2; p++) begin
            measure(hi, per);
            check($sformatf("dbl_period%0d", p), per, 200);
            check($sformatf("dbl_high%0d", p), hi, 100);
        end

        // Duty 0 gives constant low, then ramp 0 -> 10, then an immediate drop to 4
        bus.duty = 8'd0;
        @(negedge clk_sys);
        check("duty0_cur_duty", int'(bus.cur_duty), 0);
        repeat (300) @(negedge clk_sys);
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (bus.pwm) k++;
        end
        check("duty0_pwm_high_cycles", k, 0);
        bus.duty = 8'd10;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (bus.cur_duty == 8'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("ramp_first_step", int'(ok), 1);
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            k++;
            if (bus.cur_duty == 8'd10) break;
        end
        check("ramp_1_to_10_cycles", k, 9 * RAMP_US * US_CYC);
        bus.duty = 8'd4;
        @(negedge clk_sys);
        check("ramp_drop_cur_duty", int'(bus.cur_duty), 4);

        // Enable dropped in the high phase
        wait_rise(3000, ok);
        @(negedge clk_sys);
        check("en_mid_high_pwm", int'(bus.pwm), 1);
        bus.en = 1'b0;
        @(negedge clk_sys);
        check("en_off_pwm", int'(bus.pwm), 0);
        check("en_off_cur_duty", int'(bus.cur_duty), 0);
        check("en_off_busy", int'(bus.busy), 0);
        bus.en = 1'b1;
        @(negedge clk_sys);
        check("en_on_busy", int'(bus.busy), 1);
        check("en_on_cur_duty", int'(bus.cur_duty), 0);

        // Reset pulse while the division is running
        repeat (4) @(negedge clk_sys);
        check("calc_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk_sys);
        check("rst_calc_pwm", int'(bus.pwm), 0);
        check("rst_calc_cur_duty", int'(bus.cur_duty), 0);
        check("rst_calc_busy", int'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk_sys);
        check("rst_release_busy", int'(bus.busy), 1);
        settle(8'd4, ok);
        check("final_settle", int'(ok), 1);
        wait_rise(3000, ok);
        measure(hi, per);
        check("final_period", per, 200);
        check("final_high", hi, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
